// File: rtl/add_sub_pipe.sv
// ---------------------------------------------------------------------------
// add_sub_pipe
//   Pipelined two's-complement adder/subtractor. The carry chain is split
//   into SLICE-bit segments and each segment is resolved in its own register
//   stage, so WIDTH can grow without a long combinational ripple. The block
//   has valid/ready handshaking on both sides, status flags, and optional
//   signed saturation.
//
//   Stall model: a single global stall (out_valid && !out_ready) freezes every
//   stage and the output registers. Bubbles are not collapsed.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   mode       0 = a+b, 1 = a-b
//   sat        1 = clamp signed overflow to the signed limit
//   a, b       operands (WIDTH bits)
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   result     sum/difference, possibly saturated
//   carry      carry out of the MSB (subtract: 1 = no borrow)
//   overflow   signed overflow of the raw (unsaturated) result
//   zero       result == 0 (after saturation)
//   negative   result MSB (after saturation)
// ---------------------------------------------------------------------------
module add_sub_pipe #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int STAGES = WIDTH / SLICE;
    localparam int LAST   = STAGES - 1;

    // One SLICE-bit segment of the carry chain; MSB of the return is carry out.
    function automatic logic [SLICE:0] slice_add(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic             inv,
        input logic             cin
    );
        slice_add = {1'b0, x} + {1'b0, y ^ {SLICE{inv}}} + {{SLICE{1'b0}}, cin};
    endfunction

    // A wrapped positive overflow shows a negative raw sign, and vice versa.
    function automatic logic [WIDTH-1:0] saturate(
        input logic [WIDTH-1:0] raw,
        input logic             ovf,
        input logic             en
    );
        if (en && ovf) begin
            saturate = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                    : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            saturate = raw;
        end
    endfunction

    // Per-stage skew registers: entry k holds a beat waiting to resolve slice k.
    logic [STAGES-1:0] vld_p;
    logic [WIDTH-1:0]  a_p    [STAGES];
    logic [WIDTH-1:0]  b_p    [STAGES];
    logic [WIDTH-1:0]  sum_p  [STAGES];
    logic              cy_p   [STAGES];
    logic              mode_p [STAGES];
    logic              sat_p  [STAGES];

    logic [WIDTH-1:0]  sum_nxt [STAGES];
    logic              cout    [STAGES];

    logic              ready_q;
    logic              stall;

    logic [WIDTH-1:0]  raw_sum;
    logic              raw_carry;
    logic              raw_ovf;
    logic              a_msb;
    logic              bi_msb;
    logic [WIDTH-1:0]  sat_sum;

    assign stall    = out_valid && !out_ready;
    // ready_q keeps the input closed for the first cycle after reset release.
    assign in_ready = ready_q && !stall;

    // Slice resolution: each stage fills its own SLICE bits of the partial sum.
    always_comb begin
        logic [SLICE:0] slice_r;
        slice_r = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice_r    = slice_add(a_p[k][k*SLICE +: SLICE], b_p[k][k*SLICE +: SLICE],
                                   mode_p[k], cy_p[k]);
            sum_nxt[k] = sum_p[k];
            sum_nxt[k][k*SLICE +: SLICE] = slice_r[SLICE-1:0];
            cout[k]    = slice_r[SLICE];
        end
    end

    // Final stage: signed overflow is equivalent to carry-in(MSB) ^ carry-out(MSB),
    // detected here from operand/result signs so it works for any SLICE.
    assign raw_sum   = sum_nxt[LAST];
    assign raw_carry = cout[LAST];
    assign a_msb     = a_p[LAST][WIDTH-1];
    assign bi_msb    = b_p[LAST][WIDTH-1] ^ mode_p[LAST];
    assign raw_ovf   = (a_msb == bi_msb) && (raw_sum[WIDTH-1] != a_msb);
    assign sat_sum   = saturate(raw_sum, raw_ovf, sat_p[LAST]);

    // Input capture (stage 0) and slice stages 1..STAGES-1: datapath, no reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            a_p[0]    <= a;
            b_p[0]    <= b;
            mode_p[0] <= mode;
            sat_p[0]  <= sat;
            cy_p[0]   <= mode;
            sum_p[0]  <= '0;
            for (int k = 1; k < STAGES; k++) begin
                a_p[k]    <= a_p[k-1];
                b_p[k]    <= b_p[k-1];
                mode_p[k] <= mode_p[k-1];
                sat_p[k]  <= sat_p[k-1];
                sum_p[k]  <= sum_nxt[k-1];
                cy_p[k]   <= cout[k-1];
            end
        end
    end

    // Valid chain and output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q   <= 1'b0;
            vld_p     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (!stall) begin
                vld_p[0] <= in_valid && ready_q;
                for (int k = 1; k < STAGES; k++) begin
                    vld_p[k] <= vld_p[k-1];
                end
                out_valid <= vld_p[LAST];
                if (vld_p[LAST]) begin
                    result   <= sat_sum;
                    carry    <= raw_carry;
                    overflow <= raw_ovf;
                    zero     <= (sat_sum == '0);
                    negative <= sat_sum[WIDTH-1];
                end
            end
        end
    end

endmodule
